instr_fetch_decode: RTL and testbench
=====================================

Name: instr_fetch_decode

Overview:
- Instruction fetch/decode (IFD) unit of the PDP-8 core.
- Fetches the 12-bit word at the PC supplied by EXEC through a single-outstanding read port to memory.
- Decodes memory-reference (opcodes 0-5) and OPR (opcode 7) instructions into pdp_mem_opcode / pdp_op7_opcode for EXEC.
- Publishes the program start address and detects end of program when EXEC jumps back to it.

Parameters:
- START_ADDR, 12'o200, value driven on base_addr; first instruction address.
- ADDR_WIDTH, `ADDR_WIDTH (12), address and data width.

Ports:
- clk  in  1  free-running clock
- reset_n  in  1  reset; reset reset_n, synchronous, active-low; clock clk
- stall  in  1  EXEC busy; no new fetch may start while high
- PC_value  in  12  address of next instruction, from EXEC
- ifu_rd_data  in  12  memory read data
- ifu_rd_valid  in  1  ifu_rd_data valid, any cycle after the request
- ifu_rd_req  out  1  one-cycle read request
- ifu_rd_addr  out  12  read address, valid with ifu_rd_req
- base_addr  out  12  START_ADDR, constant after reset
- pdp_mem_opcode  out  pdp_mem_opcode_s  decoded memory-reference instruction
- pdp_op7_opcode  out  pdp_op7_opcode_s  decoded OPR microinstruction
- decode_valid  out  1  one-cycle pulse; opcode outputs updated this cycle
- done  out  1  sticky end-of-program flag

Behaviour:
- Reset values:
  - base_addr = START_ADDR.
  - Both opcode structs all-zero.
  - ifu_rd_req = 0, ifu_rd_addr = 0, decode_valid = 0, done = 0.
  - Internal: fetch_cnt = 0, last_pc = 0, first = 1.
- Reset is synchronous and aborts any state, including an outstanding read. Any ifu_rd_valid arriving after reset is ignored.
- FSM states: IDLE, READY, FETCH, WAIT, DECODE, DONE. Reset enters IDLE; IDLE goes to READY on the next cycle.
- READY: evaluated only when stall == 0 and (first == 1 or PC_value != last_pc).
  - If fetch_cnt != 0 and PC_value == base_addr: go to DONE.
  - Otherwise latch pc_q = PC_value and go to FETCH.
  - stall == 1, or an unchanged PC: remain in READY, outputs held.
- FETCH: ifu_rd_req = 1 and ifu_rd_addr = pc_q for exactly 1 cycle, then go to WAIT.
- WAIT: ignore stall and PC_value. On ifu_rd_valid, capture ifu_rd_data into ir and go to DECODE. No timeout.
- DECODE (1 cycle): register decoded structs and pulse decode_valid = 1. Set last_pc = pc_q, first = 0, fetch_cnt++ (saturating 16-bit), then go to READY.
- Latency, measured from the READY cycle with stall = 0 and a new PC:
  - ifu_rd_req at +1.
  - With ifu_rd_valid at +2, decode_valid and new opcode outputs at +3.
- Opcode outputs change only in DECODE and hold otherwise, regardless of stall.
- Memory-reference decode, ir[11:9] in 0..5 (IOT = 6):
  - Exactly one of AND/TAD/ISZ/DCA/JMS/JMP is set; IOT sets NOP.
  - indirect = ir[8].
  - mem_inst_addr = ir[7] ? {pc_q[11:7], ir[6:0]} : {5'b0, ir[6:0]}.
  - pdp_op7_opcode is all-zero.
- OPR decode, ir[11:9] = 7: exactly one op7 flag set, per the full-word table:
  - 7000 NOP, 7001 IAC, 7004 RAL, 7006 RTL, 7010 RAR, 7012 RTR, 7020 CML, 7040 CMA, 7041 CIA, 7100 CLL, 7200 CLA1, 7300 CLA_CLL
  - 7402 HLT, 7404 OSR, 7410 SKP, 7420 SNL, 7430 SZL, 7440 SZA, 7450 SNA, 7500 SMA, 7510 SPA, 7600 CLA2
  - Any other 7xxx sets op7 NOP.
  - pdp_mem_opcode is all-zero in every OPR case.
- DONE:
  - done = 1 and sticky until reset.
  - No further ifu_rd_req and no decode_valid.
  - Opcode outputs hold their last values.
  - All further stall/PC activity is ignored.
- PC wrap: 12'o7777 → 12'o0000 is an ordinary new PC; no special case.

Decomposition:
- pdp8_pkg holds:
  - pdp_mem_opcode_s (NOP, AND, TAD, ISZ, DCA, JMS, JMP, indirect, mem_inst_addr[11:0]).
  - pdp_op7_opcode_s (one bit per listed microinstruction plus NOP).
  - `ADDR_WIDTH, START_ADDR default, and opcode field constants.
- Sub-module: ifd_decoder, purely combinational (ir, pc_q → both structs). The FSM, registers and memory port stay in the top module.

Test Plan:
- Reset, then PC_value = 12'o200, stall = 0, mem[0o200] = 12'o1377:
  - ifu_rd_req at cycle +1 with ifu_rd_addr = 0o200.
  - decode_valid shows TAD = 1, indirect = 0, mem_inst_addr = 0o377; op7 all-zero.
- mem[0o201] = 12'o5600, PC_value = 0o201, stall held high 5 cycles then low:
  - No ifu_rd_req while stall is high.
  - Then JMP = 1, indirect = 1, mem_inst_addr = 0o200.
- Words 7041, 7402 and 7777 at successive PCs → CIA, HLT, op7 NOP respectively; pdp_mem_opcode all-zero each time.
- PC_value unchanged with stall toggling 1/0 for 20 cycles → exactly one fetch; outputs stable.
- After 3 decodes, PC_value = 0o200 with stall = 0:
  - done = 1 with no ifu_rd_req.
  - A further 5 PC increments produce no reads and no decode_valid.
- reset_n low during WAIT, with ifu_rd_valid arriving afterwards:
  - Outputs return to reset values and the late data is ignored.
  - The next fetch at 0o200 is not treated as DONE (fetch_cnt = 0).

Source files
------------

// File: rtl/pdp8_pkg.sv
// Shared types and constants for the PDP-8 core: opcode structs, field codes
// and the instruction fetch/decode state encoding.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif

package pdp8_pkg;

    localparam int unsigned      ADDR_W             = `ADDR_WIDTH;
    localparam logic [11:0]      START_ADDR_DEFAULT = 12'o200;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_TAD = 3'd1;
    localparam logic [2:0] OP_ISZ = 3'd2;
    localparam logic [2:0] OP_DCA = 3'd3;
    localparam logic [2:0] OP_JMS = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;
    localparam logic [2:0] OP_IOT = 3'd6;
    localparam logic [2:0] OP_OPR = 3'd7;

    typedef struct packed {
        logic        NOP;
        logic        AND;
        logic        TAD;
        logic        ISZ;
        logic        DCA;
        logic        JMS;
        logic        JMP;
        logic        indirect;
        logic [11:0] mem_inst_addr;
    } pdp_mem_opcode_s;

    typedef struct packed {
        logic NOP;
        logic IAC;
        logic RAL;
        logic RTL;
        logic RAR;
        logic RTR;
        logic CML;
        logic CMA;
        logic CIA;
        logic CLL;
        logic CLA1;
        logic CLA_CLL;
        logic HLT;
        logic OSR;
        logic SKP;
        logic SNL;
        logic SZL;
        logic SZA;
        logic SNA;
        logic SMA;
        logic SPA;
        logic CLA2;
    } pdp_op7_opcode_s;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READY  = 3'd1,
        ST_FETCH  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DECODE = 3'd4,
        ST_DONE   = 3'd5
    } ifd_state_e;

endpackage

// File: rtl/ifd_decoder.sv
// Combinational PDP-8 instruction decoder: memory-reference and OPR words
// into one-hot opcode structs.
module ifd_decoder
    import pdp8_pkg::*;
(
    input  logic [11:0]     ir_i,
    input  logic [4:0]      page_i,
    output pdp_mem_opcode_s mem_op_o,
    output pdp_op7_opcode_s op7_op_o
);

    // One-hot opcode selection; the OPR group is matched on the full word.
    always_comb begin
        mem_op_o = '0;
        op7_op_o = '0;
        case (ir_i[11:9])
            OP_AND: mem_op_o.AND = 1'b1;
            OP_TAD: mem_op_o.TAD = 1'b1;
            OP_ISZ: mem_op_o.ISZ = 1'b1;
            OP_DCA: mem_op_o.DCA = 1'b1;
            OP_JMS: mem_op_o.JMS = 1'b1;
            OP_JMP: mem_op_o.JMP = 1'b1;
            OP_IOT: mem_op_o.NOP = 1'b1;
            OP_OPR: begin
                case (ir_i)
                    12'o7000: op7_op_o.NOP     = 1'b1;
                    12'o7001: op7_op_o.IAC     = 1'b1;
                    12'o7004: op7_op_o.RAL     = 1'b1;
                    12'o7006: op7_op_o.RTL     = 1'b1;
                    12'o7010: op7_op_o.RAR     = 1'b1;
                    12'o7012: op7_op_o.RTR     = 1'b1;
                    12'o7020: op7_op_o.CML     = 1'b1;
                    12'o7040: op7_op_o.CMA     = 1'b1;
                    12'o7041: op7_op_o.CIA     = 1'b1;
                    12'o7100: op7_op_o.CLL     = 1'b1;
                    12'o7200: op7_op_o.CLA1    = 1'b1;
                    12'o7300: op7_op_o.CLA_CLL = 1'b1;
                    12'o7402: op7_op_o.HLT     = 1'b1;
                    12'o7404: op7_op_o.OSR     = 1'b1;
                    12'o7410: op7_op_o.SKP     = 1'b1;
                    12'o7420: op7_op_o.SNL     = 1'b1;
                    12'o7430: op7_op_o.SZL     = 1'b1;
                    12'o7440: op7_op_o.SZA     = 1'b1;
                    12'o7450: op7_op_o.SNA     = 1'b1;
                    12'o7500: op7_op_o.SMA     = 1'b1;
                    12'o7510: op7_op_o.SPA     = 1'b1;
                    12'o7600: op7_op_o.CLA2    = 1'b1;
                    default:  op7_op_o.NOP     = 1'b1;
                endcase
            end
            default: mem_op_o.NOP = 1'b1;
        endcase

        // Operand addressing only applies to true memory-reference opcodes;
        // bit 7 selects the current page instead of page zero.
        if (ir_i[11:9] <= OP_JMP) begin
            mem_op_o.indirect      = ir_i[8];
            mem_op_o.mem_inst_addr = ir_i[7] ? {page_i, ir_i[6:0]} : {5'b00000, ir_i[6:0]};
        end else begin
            mem_op_o.indirect      = 1'b0;
            mem_op_o.mem_inst_addr = 12'o0000;
        end
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// PDP-8 instruction fetch/decode unit: single-outstanding fetch at the PC
// given by EXEC, decode into opcode structs, end-of-program detection.
module instr_fetch_decode
    import pdp8_pkg::*;
#(
    parameter int                    ADDR_WIDTH = `ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = START_ADDR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  stall,
    input  logic [ADDR_WIDTH-1:0] PC_value,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_data,
    input  logic                  ifu_rd_valid,
    output logic                  ifu_rd_req,
    output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic [ADDR_WIDTH-1:0] base_addr,
    output pdp_mem_opcode_s       pdp_mem_opcode,
    output pdp_op7_opcode_s       pdp_op7_opcode,
    output logic                  decode_valid,
    output logic                  done
);

    ifd_state_e            state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] last_pc_q;
    logic                  first_q;
    logic [15:0]           fetch_cnt_q;
    logic [15:0]           fetch_cnt_d;
    logic                  rd_req_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH-1:0] base_addr_q;
    logic                  decode_valid_q;
    logic                  done_q;
    pdp_mem_opcode_s       mem_op_q;
    pdp_op7_opcode_s       op7_op_q;
    pdp_mem_opcode_s       mem_op_s;
    pdp_op7_opcode_s       op7_op_s;
    logic                  pc_new_s;

    // The decoder sees the read data directly so the structs can be
    // registered on the same edge that accepts ifu_rd_valid.
    ifd_decoder u_decoder (
        .ir_i     (ifu_rd_data),
        .page_i   (pc_q[ADDR_WIDTH-1:ADDR_WIDTH-5]),
        .mem_op_o (mem_op_s),
        .op7_op_o (op7_op_s)
    );

    assign fetch_cnt_d = (&fetch_cnt_q) ? fetch_cnt_q : fetch_cnt_q + 16'd1;
    assign pc_new_s    = first_q || (PC_value != last_pc_q);

    // Fetch/decode sequencer with registered memory-port and decode outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            pc_q           <= '0;
            last_pc_q      <= '0;
            first_q        <= 1'b1;
            fetch_cnt_q    <= 16'd0;
            rd_req_q       <= 1'b0;
            rd_addr_q      <= '0;
            base_addr_q    <= START_ADDR;
            decode_valid_q <= 1'b0;
            done_q         <= 1'b0;
            mem_op_q       <= '0;
            op7_op_q       <= '0;
        end else begin
            rd_req_q       <= 1'b0;
            decode_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: state_q <= ST_READY;
                ST_READY: begin
                    if (!stall && pc_new_s) begin
                        if ((fetch_cnt_q != 16'd0) && (PC_value == base_addr_q)) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            pc_q      <= PC_value;
                            rd_req_q  <= 1'b1;
                            rd_addr_q <= PC_value;
                            state_q   <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (ifu_rd_valid) begin
                        mem_op_q       <= mem_op_s;
                        op7_op_q       <= op7_op_s;
                        decode_valid_q <= 1'b1;
                        state_q        <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    last_pc_q   <= pc_q;
                    first_q     <= 1'b0;
                    fetch_cnt_q <= fetch_cnt_d;
                    state_q     <= ST_READY;
                end
                ST_DONE: done_q <= 1'b1;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ifu_rd_req     = rd_req_q;
    assign ifu_rd_addr    = rd_addr_q;
    assign base_addr      = base_addr_q;
    assign pdp_mem_opcode = mem_op_q;
    assign pdp_op7_opcode = op7_op_q;
    assign decode_valid   = decode_valid_q;
    assign done           = done_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: a bench-side memory responder and
// hand-computed expected opcode structs.
module tb_instr_fetch_decode;
    import pdp8_pkg::*;

    logic            clk;
    logic            reset_n;
    logic            stall;
    logic [11:0]     PC_value;
    logic [11:0]     ifu_rd_data;
    logic            ifu_rd_valid;
    logic            ifu_rd_req;
    logic [11:0]     ifu_rd_addr;
    logic [11:0]     base_addr;
    pdp_mem_opcode_s mem_op;
    pdp_op7_opcode_s op7_op;
    logic            decode_valid;
    logic            done;

    int checks;
    int failures;

    instr_fetch_decode dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .PC_value       (PC_value),
        .ifu_rd_data    (ifu_rd_data),
        .ifu_rd_valid   (ifu_rd_valid),
        .ifu_rd_req     (ifu_rd_req),
        .ifu_rd_addr    (ifu_rd_addr),
        .base_addr      (base_addr),
        .pdp_mem_opcode (mem_op),
        .pdp_op7_opcode (op7_op),
        .decode_valid   (decode_valid),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for a read request, answers one cycle later and waits for the decode pulse.
    task automatic serve(input logic [11:0] word, output bit got_req, output int req_idx,
                         output logic [11:0] addr_seen, output bit got_dv, output int lat);
        got_req = 1'b0; got_dv = 1'b0; req_idx = -1; addr_seen = 12'o0000; lat = 0;
        for (int i = 0; i < 20 && !got_req; i++) begin
            @(negedge clk);
            if (ifu_rd_req === 1'b1) begin
                got_req   = 1'b1;
                req_idx   = i;
                addr_seen = ifu_rd_addr;
            end
        end
        if (got_req) begin
            tick();
            ifu_rd_valid = 1'b1;
            ifu_rd_data  = word;
            tick();
            ifu_rd_valid = 1'b0;
            lat = 1;
            for (int i = 0; i < 10 && !got_dv; i++) begin
                @(negedge clk);
                lat++;
                if (decode_valid === 1'b1) got_dv = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; stall = 1'b0; PC_value = 12'o200;
        ifu_rd_valid = 1'b0; ifu_rd_data = 12'o0000;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (ifu_rd_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", ifu_rd_req); end
        checks++; if (ifu_rd_addr !== 12'o0000) begin failures++; $display("FAIL reset_addr: got %o expected 0", ifu_rd_addr); end
        checks++; if (base_addr !== 12'o200) begin failures++; $display("FAIL reset_base: got %o expected 200", base_addr); end
        checks++; if (decode_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_flags: got dv=%b done=%b expected 0 0", decode_valid, done); end
        checks++; if (mem_op !== '0 || op7_op !== '0) begin failures++; $display("FAIL reset_opcodes: got mem=%h op7=%h expected 0 0", mem_op, op7_op); end
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_first_fetch();
        bit got_req, got_dv; int idx, lat; logic [11:0] a;
        pdp_mem_opcode_s exp;
        exp = '0; exp.TAD = 1'b1; exp.mem_inst_addr = 12'o377;
        serve(12'o1377, got_req, idx, a, got_dv, lat);
        checks++; if (!got_req || idx != 2) begin failures++; $display("FAIL first_req_timing: got req=%0d idx=%0d expected 1 2", got_req, idx); end
        checks++; if (a !== 12'o200) begin failures++; $display("FAIL first_req_addr: got %o expected 200", a); end
        checks++; if (!got_dv || lat != 2) begin failures++; $display("FAIL first_dv_latency: got dv=%0d lat=%0d expected 1 2", got_dv, lat); end
        checks++; if (mem_op !== exp) begin failures++; $display("FAIL first_tad: got %h expected %h", mem_op, exp); end
        checks++; if (op7_op !== '0) begin failures++; $display("FAIL first_op7_zero: got %h expected 0", op7_op); end
    endtask

    task automatic test_stall();
        bit got_req, got_dv; int idx, lat, n; logic [11:0] a;
        pdp_mem_opcode_s exp;
        exp = '0; exp.JMP = 1'b1; exp.indirect = 1'b1; exp.mem_inst_addr = 12'o200;
        n = 0;
        tick();
        stall = 1'b1; PC_value = 12'o201;
        repeat (5) begin
            @(negedge clk);
            if (ifu_rd_req === 1'b1) n++;
            tick();
        end
        checks++; if (n != 0) begin failures++; $display("FAIL stall_no_req: got %0d requests expected 0", n); end
        stall = 1'b0;
        serve(12'o5600, got_req, idx, a, got_dv, lat);
        checks++; if (!got_req || a !== 12'o201) begin failures++; $display("FAIL stall_req_addr: got req=%0d addr=%o expected 1 201", got_req, a); end
        checks++; if (!got_dv || mem_op !== exp) begin failures++; $display("FAIL stall_jmp: got dv=%0d mem=%h expected 1 %h", got_dv, mem_op, exp); end
    endtask

    task automatic test_opr();
        bit got_req, got_dv; int idx, lat; logic [11:0] a;
        logic [11:0]     words [3];
        pdp_op7_opcode_s exps  [3];
        words[0] = 12'o7041; words[1] = 12'o7402; words[2] = 12'o7777;
        exps[0] = '0; exps[0].CIA = 1'b1;
        exps[1] = '0; exps[1].HLT = 1'b1;
        exps[2] = '0; exps[2].NOP = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            PC_value = 12'o202 + 12'(k);
            serve(words[k], got_req, idx, a, got_dv, lat);
            checks++; if (!got_dv || op7_op !== exps[k]) begin failures++; $display("FAIL opr_%0o: got dv=%0d op7=%h expected 1 %h", words[k], got_dv, op7_op, exps[k]); end
            checks++; if (mem_op !== '0) begin failures++; $display("FAIL opr_mem_zero_%0o: got %h expected 0", words[k], mem_op); end
        end
    endtask

    task automatic test_back_to_back_same_pc();
        int nreq, ndv; bit pend;
        pdp_op7_opcode_s exp;
        exp = '0; exp.IAC = 1'b1;
        nreq = 0; ndv = 0; pend = 1'b0;
        PC_value = 12'o205;
        for (int i = 0; i < 20; i++) begin
            tick();
            stall        = i[0];
            ifu_rd_valid = pend;
            ifu_rd_data  = 12'o7001;
            pend         = 1'b0;
            @(negedge clk);
            if (ifu_rd_req === 1'b1) begin nreq++; pend = 1'b1; end
            if (decode_valid === 1'b1) ndv++;
        end
        tick();
        stall = 1'b0; ifu_rd_valid = 1'b0;
        checks++; if (nreq != 1) begin failures++; $display("FAIL same_pc_fetches: got %0d expected 1", nreq); end
        checks++; if (ndv != 1) begin failures++; $display("FAIL same_pc_decodes: got %0d expected 1", ndv); end
        checks++; if (op7_op !== exp) begin failures++; $display("FAIL same_pc_iac: got %h expected %h", op7_op, exp); end
    endtask

    task automatic test_done();
        int nreq, ndv; bit seen;
        pdp_op7_opcode_s exp;
        exp = '0; exp.IAC = 1'b1;
        nreq = 0; ndv = 0; seen = 1'b0;
        PC_value = 12'o200;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (ifu_rd_req === 1'b1) nreq++;
            if (done === 1'b1) seen = 1'b1;
            tick();
        end
        checks++; if (!seen || nreq != 0) begin failures++; $display("FAIL done_detect: got done=%0d reqs=%0d expected 1 0", seen, nreq); end
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            if (!i[0]) PC_value = PC_value + 12'o1;
            @(negedge clk);
            if (ifu_rd_req === 1'b1) nreq++;
            if (decode_valid === 1'b1) ndv++;
            tick();
        end
        checks++; if (nreq != 0 || ndv != 0) begin failures++; $display("FAIL done_quiet: got reqs=%0d dv=%0d expected 0 0", nreq, ndv); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL done_sticky: got %b expected 1", done); end
        checks++; if (op7_op !== exp) begin failures++; $display("FAIL done_hold: got %h expected %h", op7_op, exp); end
    endtask

    task automatic test_reset_in_wait();
        bit got_req, got_dv; int idx, lat; logic [11:0] a; bit late_dv;
        pdp_mem_opcode_s exp;
        exp = '0; exp.DCA = 1'b1; exp.mem_inst_addr = 12'o010;
        reset_n = 1'b0; PC_value = 12'o200; stall = 1'b0;
        tick();
        reset_n = 1'b1;
        got_req = 1'b0;
        for (int i = 0; i < 10 && !got_req; i++) begin
            @(negedge clk);
            if (ifu_rd_req === 1'b1) got_req = 1'b1;
        end
        checks++; if (!got_req) begin failures++; $display("FAIL rst_first_req: got none expected request"); end
        tick();
        reset_n = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (ifu_rd_req !== 1'b0 || decode_valid !== 1'b0 || done !== 1'b0 || ifu_rd_addr !== 12'o0000) begin
            failures++; $display("FAIL rst_wait_outputs: got req=%b dv=%b done=%b addr=%o expected 0 0 0 0", ifu_rd_req, decode_valid, done, ifu_rd_addr);
        end
        tick();
        reset_n = 1'b1; ifu_rd_valid = 1'b1; ifu_rd_data = 12'o7402;
        @(negedge clk);
        late_dv = decode_valid;
        tick();
        ifu_rd_valid = 1'b0;
        @(negedge clk);
        late_dv = late_dv | decode_valid;
        checks++; if (late_dv !== 1'b0 || op7_op !== '0) begin failures++; $display("FAIL rst_late_data: got dv=%b op7=%h expected 0 0", late_dv, op7_op); end
        serve(12'o3010, got_req, idx, a, got_dv, lat);
        checks++; if (!got_req || a !== 12'o200 || done !== 1'b0) begin failures++; $display("FAIL rst_refetch: got req=%0d addr=%o done=%b expected 1 200 0", got_req, a, done); end
        checks++; if (!got_dv || mem_op !== exp) begin failures++; $display("FAIL rst_dca: got dv=%0d mem=%h expected 1 %h", got_dv, mem_op, exp); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_first_fetch();
        test_stall();
        test_opr();
        test_back_to_back_same_pc();
        test_done();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
